// File: rtl/ifu_fetch.sv
`default_nettype none
//============================================================================
// Module   : ifu_fetch
// Desc     : Instruction fetch stage. Takes addresses from the PC unit,
//            issues single-word requests to instruction memory and pairs
//            in-order responses with their addresses in a fetch queue that
//            feeds decode. A flush drops buffered and in-flight fetches.
// Option   : IFU_MISALIGN_CHECK_EN - misaligned addresses skip memory and
//            are queued as fault entries in program order.
// Revision : 1.0 - initial release
//============================================================================
module ifu_fetch #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_valid_i,
    input  logic [31:0] pc_addr_i,
    output logic        pc_ready_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_fault_o,
    input  logic        dec_ready_i
);
    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_CW    = c_AW + 1;
    localparam logic [c_CW:0]   c_DEPTH = (c_CW + 1)'(DEPTH);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);
    localparam logic [c_AW-1:0] c_PONE  = c_AW'(1);

    // request register and credit counters
    logic            r_req_pending;
    logic [31:0]     r_req_addr;
    logic [c_CW-1:0] r_inflight;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] r_discard;

    // address FIFO for granted requests, and the fetch queue
    logic [31:0]     r_af_mem [DEPTH];
    logic [c_AW-1:0] r_af_wptr;
    logic [c_AW-1:0] r_af_rptr;
    logic [31:0]     r_q_addr [DEPTH];
    logic [31:0]     r_q_data [DEPTH];
    logic [c_AW-1:0] r_q_wptr;
    logic [c_AW-1:0] r_q_rptr;

    logic            w_grant;
    logic            w_accept;
    logic            w_credit_ok;
    logic [c_CW:0]   w_used;
    logic            w_rsp_keep;
    logic            w_q_push;
    logic            w_q_pop;
    logic [31:0]     w_push_addr;
    logic [31:0]     w_push_data;
    logic [c_CW-1:0] w_inflight_nxt;
    logic [c_CW-1:0] w_count_nxt;
    logic            w_misaligned;
    logic            w_byp_valid;
    logic            w_byp_go;
    logic [31:0]     w_byp_addr;

    assign w_grant     = imem_gnt_i && r_req_pending;
    assign w_used      = {1'b0, r_inflight} + {1'b0, r_count}
                       + {{c_CW{1'b0}}, r_req_pending} + {{c_CW{1'b0}}, w_byp_valid};
    assign w_credit_ok = (w_used < c_DEPTH);
    // a held bypass entry blocks new addresses so nothing can overtake it
    assign pc_ready_o  = !flush_i && w_credit_ok && (!r_req_pending || imem_gnt_i) && !w_byp_valid;
    assign w_accept    = pc_valid_i && pc_ready_o;

    // responses owed to a flushed stream are dropped without touching the FIFO
    assign w_rsp_keep  = imem_rvalid_i && (r_discard == '0);
    assign w_q_push    = w_rsp_keep || w_byp_go;
    assign w_q_pop     = inst_valid_o && dec_ready_i;
    assign w_push_addr = w_byp_go ? w_byp_addr : r_af_mem[r_af_rptr];
    assign w_push_data = w_byp_go ? 32'h0 : imem_rdata_i;

    assign imem_req_o   = r_req_pending;
    assign inst_valid_o = (r_count != '0);
    assign inst_o       = inst_valid_o ? r_q_data[r_q_rptr] : 32'h0;
    assign inst_addr_o  = inst_valid_o ? r_q_addr[r_q_rptr] : 32'h0;

`ifdef IFU_MISALIGN_CHECK_EN
    logic        r_byp_valid;
    logic [31:0] r_byp_addr;
    logic        r_q_fault [DEPTH];

    assign w_misaligned = (pc_addr_i[1:0] != 2'b00);
    assign w_byp_valid  = r_byp_valid;
    assign w_byp_addr   = r_byp_addr;
    // release the fault entry only once every older fetch has returned
    assign w_byp_go     = r_byp_valid && (r_inflight == '0) && !r_req_pending;
    assign imem_addr_o  = r_req_addr;
    assign inst_fault_o = inst_valid_o && r_q_fault[r_q_rptr];

    // bypass slot holding a misaligned address until it may be queued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byp_valid <= 1'b0;
            r_byp_addr  <= 32'h0;
        end else if (flush_i) begin
            r_byp_valid <= 1'b0;
        end else if (w_accept && w_misaligned) begin
            r_byp_valid <= 1'b1;
            r_byp_addr  <= pc_addr_i;
        end else if (w_byp_go) begin
            r_byp_valid <= 1'b0;
        end
    end

    // fault flag storage alongside the queue payload
    always_ff @(posedge clk) begin
        if (w_q_push) r_q_fault[r_q_wptr] <= w_byp_go;
    end
`else
    assign w_misaligned = 1'b0;
    assign w_byp_valid  = 1'b0;
    assign w_byp_addr   = 32'h0;
    assign w_byp_go     = 1'b0;
    assign imem_addr_o  = {r_req_addr[31:2], 2'b00};
    assign inst_fault_o = 1'b0;
`endif

    // next values of the in-flight and occupancy counters
    always_comb begin
        w_inflight_nxt = r_inflight;
        w_count_nxt    = r_count;
        if (w_grant && !imem_rvalid_i)      w_inflight_nxt = r_inflight + c_ONE;
        else if (!w_grant && imem_rvalid_i) w_inflight_nxt = r_inflight - c_ONE;
        if (w_q_push && !w_q_pop)           w_count_nxt = r_count + c_ONE;
        else if (!w_q_push && w_q_pop)      w_count_nxt = r_count - c_ONE;
    end

    // request, credit and pointer state; flush keeps only the in-flight count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_pending <= 1'b0;
            r_req_addr    <= 32'h0;
            r_inflight    <= '0;
            r_count       <= '0;
            r_discard     <= '0;
            r_af_wptr     <= '0;
            r_af_rptr     <= '0;
            r_q_wptr      <= '0;
            r_q_rptr      <= '0;
        end else if (flush_i) begin
            r_req_pending <= 1'b0;
            r_inflight    <= w_inflight_nxt;
            r_discard     <= w_inflight_nxt;
            r_count       <= '0;
            r_af_wptr     <= '0;
            r_af_rptr     <= '0;
            r_q_wptr      <= '0;
            r_q_rptr      <= '0;
        end else begin
            if (w_accept && !w_misaligned) begin
                r_req_pending <= 1'b1;
                r_req_addr    <= pc_addr_i;
            end else if (w_grant) begin
                r_req_pending <= 1'b0;
            end
            if (w_grant) r_af_wptr <= r_af_wptr + c_PONE;
            if (imem_rvalid_i) begin
                if (r_discard != '0) r_discard <= r_discard - c_ONE;
                else                 r_af_rptr <= r_af_rptr + c_PONE;
            end
            r_inflight <= w_inflight_nxt;
            r_count    <= w_count_nxt;
            if (w_q_push) r_q_wptr <= r_q_wptr + c_PONE;
            if (w_q_pop)  r_q_rptr <= r_q_rptr + c_PONE;
        end
    end

    // storage arrays; contents beyond the live pointers are never observed
    always_ff @(posedge clk) begin
        if (w_grant) r_af_mem[r_af_wptr] <= r_req_addr;
        if (w_q_push) begin
            r_q_addr[r_q_wptr] <= w_push_addr;
            r_q_data[r_q_wptr] <= w_push_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
//============================================================================
// Module   : tb_ifu_fetch
// Desc     : Self-checking bench for ifu_fetch (DEPTH=4): cycle vectors for
//            streaming and grant stalls, then sequences for queue fill,
//            reset, flush and (with IFU_MISALIGN_CHECK_EN) fault entries.
// Revision : 1.0 - initial release
//============================================================================
module tb_ifu_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        pc_valid_i;
    logic [31:0] pc_addr_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_fault_o;
    logic        dec_ready_i;

    ifu_fetch #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .pc_valid_i(pc_valid_i), .pc_addr_i(pc_addr_i), .pc_ready_o(pc_ready_o),
        .flush_i(flush_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .inst_fault_o(inst_fault_o), .dec_ready_i(dec_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [31:0] pa;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        dr;
        logic        e_rdy;
        logic        e_req;
        logic [31:0] e_maddr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ia;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    vec_t        tbl[$];
    rsp_t        rq[$];
    int          cyc = 0;
    int          mem_lat = 1;
    logic        mem_gnt_en = 1'b1;
    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] got_a [2];
    logic [31:0] got_d [2];
    logic        got_f [2];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic pv, input logic [31:0] pa, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic dr, input logic rdy, input logic req,
                       input logic [31:0] maddr, input logic iv, input logic [31:0] inst,
                       input logic [31:0] ia);
        vec_t v;
        v.pv = pv; v.pa = pa; v.gnt = gnt; v.rv = rv; v.rd = rd; v.dr = dr;
        v.e_rdy = rdy; v.e_req = req; v.e_maddr = maddr; v.e_iv = iv; v.e_inst = inst; v.e_ia = ia;
        tbl.push_back(v);
    endtask

    // one clock of the memory model: grants seen before the edge return after mem_lat cycles
    task automatic step();
        logic        g;
        logic [31:0] a;
        rsp_t        r;
        g = imem_req_o && imem_gnt_i;
        a = imem_addr_o;
        @(posedge clk);
        cyc++;
        if (g) begin
            r.due  = cyc + mem_lat - 1;
            r.data = mem_word(a);
            rq.push_back(r);
        end
        #1;
        imem_gnt_i = mem_gnt_en;
        if (rq.size() != 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = r.data;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pc_valid_i = 1'b0; flush_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        rq.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        imem_gnt_i = mem_gnt_en;
    endtask

    task automatic fill(input logic [31:0] base, output int acc);
        acc = 0;
        dec_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pc_valid_i = 1'b1;
            pc_addr_i  = base + 32'(4 * acc);
            #2;
            if (pc_ready_o) acc++;
            step();
        end
        pc_valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   acc;
        int   idx;
        int   n_got;
        int   bad;
        logic found;
        logic [31:0] fa;
        logic [31:0] fd;

        reset = 1'b1;
        pc_valid_i = 1'b0; pc_addr_i = 32'h0; flush_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        dec_ready_i = 1'b1;

        repeat (2) @(posedge clk);
        #2;
        chk("rst pc_ready", 32'(pc_ready_o), 32'd1);
        chk("rst imem_req", 32'(imem_req_o), 32'd0);
        chk("rst imem_addr", imem_addr_o, 32'h0);
        chk("rst inst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst inst", inst_o, 32'h0);
        chk("rst inst_addr", inst_addr_o, 32'h0);
        chk("rst inst_fault", 32'(inst_fault_o), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // pv pa gnt rv rd dr | rdy req maddr iv inst ia
        add(1, 32'h00, 0, 0, 32'h0,            1, 1, 0, 32'h00, 0, 32'h0,            32'h00);
        add(1, 32'h04, 1, 0, 32'h0,            1, 1, 1, 32'h00, 0, 32'h0,            32'h00);
        add(1, 32'h08, 1, 1, mem_word(32'h00), 1, 1, 1, 32'h04, 0, 32'h0,            32'h00);
        add(1, 32'h0C, 1, 1, mem_word(32'h04), 1, 1, 1, 32'h08, 1, mem_word(32'h00), 32'h00);
        add(0, 32'h00, 1, 1, mem_word(32'h08), 1, 1, 1, 32'h0C, 1, mem_word(32'h04), 32'h04);
        add(1, 32'h10, 0, 1, mem_word(32'h0C), 1, 1, 0, 32'h0C, 1, mem_word(32'h08), 32'h08);
        add(1, 32'h14, 0, 0, 32'h0,            1, 0, 1, 32'h10, 1, mem_word(32'h0C), 32'h0C);
        add(1, 32'h14, 0, 0, 32'h0,            1, 0, 1, 32'h10, 0, 32'h0,            32'h00);
        add(1, 32'h14, 0, 0, 32'h0,            1, 0, 1, 32'h10, 0, 32'h0,            32'h00);
        add(1, 32'h14, 1, 0, 32'h0,            1, 1, 1, 32'h10, 0, 32'h0,            32'h00);
        add(0, 32'h00, 1, 1, mem_word(32'h10), 0, 1, 1, 32'h14, 0, 32'h0,            32'h00);
        add(0, 32'h00, 0, 1, mem_word(32'h14), 0, 1, 0, 32'h14, 1, mem_word(32'h10), 32'h10);
        add(0, 32'h00, 0, 0, 32'h0,            1, 1, 0, 32'h14, 1, mem_word(32'h10), 32'h10);
        add(0, 32'h00, 0, 0, 32'h0,            1, 1, 0, 32'h14, 1, mem_word(32'h14), 32'h14);
        add(0, 32'h00, 0, 0, 32'h0,            1, 1, 0, 32'h14, 0, 32'h0,            32'h00);
`ifndef IFU_MISALIGN_CHECK_EN
        add(1, 32'h1A, 0, 0, 32'h0,            1, 1, 0, 32'h14, 0, 32'h0,            32'h00);
        add(0, 32'h00, 1, 0, 32'h0,            1, 1, 1, 32'h18, 0, 32'h0,            32'h00);
        add(0, 32'h00, 0, 1, 32'h1234_5678,    1, 1, 0, 32'h18, 0, 32'h0,            32'h00);
        add(0, 32'h00, 0, 0, 32'h0,            1, 1, 0, 32'h18, 1, 32'h1234_5678,    32'h1A);
        add(0, 32'h00, 0, 0, 32'h0,            1, 1, 0, 32'h18, 0, 32'h0,            32'h00);
`endif

        foreach (tbl[k]) begin
            pc_valid_i = tbl[k].pv; pc_addr_i = tbl[k].pa;
            imem_gnt_i = tbl[k].gnt; imem_rvalid_i = tbl[k].rv; imem_rdata_i = tbl[k].rd;
            dec_ready_i = tbl[k].dr;
            #2;
            chk($sformatf("v%0d pc_ready", k), 32'(pc_ready_o), 32'(tbl[k].e_rdy));
            chk($sformatf("v%0d imem_req", k), 32'(imem_req_o), 32'(tbl[k].e_req));
            chk($sformatf("v%0d imem_addr", k), imem_addr_o, tbl[k].e_maddr);
            chk($sformatf("v%0d inst_valid", k), 32'(inst_valid_o), 32'(tbl[k].e_iv));
            chk($sformatf("v%0d inst", k), inst_o, tbl[k].e_inst);
            chk($sformatf("v%0d inst_addr", k), inst_addr_o, tbl[k].e_ia);
            @(posedge clk); #1;
        end

        // decode stalled: exactly DEPTH fetches taken, then drained in order
        pc_valid_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
        mem_lat = 1; mem_gnt_en = 1'b1; imem_gnt_i = 1'b1; rq.delete();
        fill(32'h200, acc);
        #2;
        chk("fill accepted", 32'(acc), 32'd4);
        chk("fill pc_ready", 32'(pc_ready_o), 32'd0);
        dec_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) #2;
            chk($sformatf("drain%0d valid", i), 32'(inst_valid_o), 32'd1);
            chk($sformatf("drain%0d addr", i), inst_addr_o, 32'h200 + 32'(4 * i));
            chk($sformatf("drain%0d inst", i), inst_o, mem_word(32'h200 + 32'(4 * i)));
            step();
        end
        #2;
        chk("drain empty", 32'(inst_valid_o), 32'd0);
        step();

        // reset while the queue is full clears outputs immediately
        fill(32'h400, acc);
        reset = 1'b1;
        #1;
        chk("midrst inst_valid", 32'(inst_valid_o), 32'd0);
        chk("midrst inst", inst_o, 32'h0);
        chk("midrst inst_addr", inst_addr_o, 32'h0);
        chk("midrst imem_req", 32'(imem_req_o), 32'd0);
        chk("midrst imem_addr", imem_addr_o, 32'h0);
        chk("midrst pc_ready", 32'(pc_ready_o), 32'd1);
        do_reset();

        // flush with two responses in flight; first delivery must be 0x100
        mem_lat = 3; dec_ready_i = 1'b1;
        pc_valid_i = 1'b1; pc_addr_i = 32'h300;
        #2; chk("fl acc0", 32'(pc_ready_o), 32'd1); step();
        pc_addr_i = 32'h304;
        #2; chk("fl acc1", 32'(pc_ready_o), 32'd1); step();
        pc_valid_i = 1'b0;
        #2; step();
        flush_i = 1'b1; pc_valid_i = 1'b1; pc_addr_i = 32'h100;
        #2; chk("fl pc_ready during flush", 32'(pc_ready_o), 32'd0); step();
        acc = 0; found = 1'b0; fa = 32'h0; fd = 32'h0;
        for (int i = 0; i < 20; i++) begin
            flush_i = 1'b0;
            pc_valid_i = (acc == 0);
            pc_addr_i = 32'h100;
            #2;
            if (i == 0) begin
                chk("fl inst_valid after", 32'(inst_valid_o), 32'd0);
                chk("fl imem_req after", 32'(imem_req_o), 32'd0);
            end
            if (inst_valid_o && !found) begin
                found = 1'b1; fa = inst_addr_o; fd = inst_o;
            end
            if (pc_valid_i && pc_ready_o) acc = 1;
            step();
        end
        pc_valid_i = 1'b0;
        chk("fl delivered", 32'(found), 32'd1);
        chk("fl first addr", fa, 32'h100);
        chk("fl first inst", fd, mem_word(32'h100));

`ifdef IFU_MISALIGN_CHECK_EN
        // aligned 0x8 then misaligned 0xA: fault entry kept in order, never requested
        mem_lat = 1;
        do_reset();
        dec_ready_i = 1'b1; idx = 0; n_got = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            pc_valid_i = (idx < 2);
            pc_addr_i  = (idx == 0) ? 32'h8 : 32'hA;
            #2;
            if (imem_req_o && imem_addr_o == 32'hA) bad++;
            if (inst_valid_o && n_got < 2) begin
                got_a[n_got] = inst_addr_o; got_d[n_got] = inst_o; got_f[n_got] = inst_fault_o;
                n_got++;
            end
            if (pc_valid_i && pc_ready_o) idx++;
            step();
        end
        pc_valid_i = 1'b0;
        chk("mis count", 32'(n_got), 32'd2);
        chk("mis no request", 32'(bad), 32'd0);
        chk("mis e0 addr", got_a[0], 32'h8);
        chk("mis e0 inst", got_d[0], mem_word(32'h8));
        chk("mis e0 fault", 32'(got_f[0]), 32'd0);
        chk("mis e1 addr", got_a[1], 32'hA);
        chk("mis e1 inst", got_d[1], 32'h0);
        chk("mis e1 fault", 32'(got_f[1]), 32'd1);
`else
        idx = 0; n_got = 0; bad = 0;
        got_a[0] = 32'h0; got_d[0] = 32'h0; got_f[0] = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
